// File: rtl/reg_sel_pkg.sv
// Shared types, default field layout and helpers for the register select sequencer.
package reg_sel_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 4;
  localparam int unsigned DEF_RA_LSB = 23;
  localparam int unsigned DEF_RB_LSB = 19;
  localparam int unsigned DEF_RC_LSB = 15;
  localparam int unsigned DEF_C_W    = 19;

  // Widest datapath the sign-extend helper supports.
  localparam int unsigned SEXT_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ_B  = 3'd1,
    READ_C  = 3'd2,
    WRITE_A = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

  // Sign-extend the low src_w bits of val to the full helper width.
  function automatic logic [SEXT_MAX_W-1:0] sign_extend(
    input logic [SEXT_MAX_W-1:0] val,
    input int unsigned           src_w
  );
    logic [SEXT_MAX_W-1:0] hi_mask;
    logic                  sgn;
    hi_mask = {SEXT_MAX_W{1'b1}} << src_w;
    sgn     = |(val & (SEXT_MAX_W'(1) << (src_w - 1)));
    return sgn ? (val | hi_mask) : (val & ~hi_mask);
  endfunction

endpackage

// File: rtl/reg_decoder.sv
// Index to one-hot decoder with an enable; all-zero output when disabled.
module reg_decoder #(
  parameter int unsigned AW = 4
) (
  input  logic [AW-1:0]        idx,
  input  logic                 en,
  output logic [(1<<AW)-1:0]   onehot
);

  // Single hot bit at the selected index.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_select_sequencer.sv
// Register select/encode with a private IR copy and a three-operand sequencer.
module reg_select_sequencer
  import reg_sel_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned RA_LSB = DEF_RA_LSB,
  parameter int unsigned RB_LSB = DEF_RB_LSB,
  parameter int unsigned RC_LSB = DEF_RC_LSB,
  parameter int unsigned C_W    = DEF_C_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       ir_in,
  input  logic                    ir_load,
  input  logic                    gra,
  input  logic                    grb,
  input  logic                    grc,
  input  logic                    rin,
  input  logic                    rout,
  input  logic                    baout,
  input  logic                    seq_start,
  input  logic                    seq_imm,
  input  logic                    res_valid,
  output logic [(1<<REG_AW)-1:0]  reg_in,
  output logic [(1<<REG_AW)-1:0]  reg_out,
  output logic                    zero_out,
  output logic                    c_out,
  output logic [DATA_W-1:0]       c_sext,
  output logic                    opa_load,
  output logic                    opb_load,
  output logic                    seq_busy,
  output logic                    seq_done
);

  localparam int unsigned NUM_REGS = 1 << REG_AW;

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              imm_q, imm_d;

  logic [REG_AW-1:0] ra_idx, rb_idx, rc_idx;
  logic [REG_AW-1:0] sel_idx;
  logic              sel_vld;
  logic              in_stb;
  logic              out_stb;
  logic              ba_stb;
  logic              c_drv;
  logic              opa_drv;
  logic              opb_drv;
  logic              done_drv;
  logic              idx_zero;
  logic [NUM_REGS-1:0] dec_oh;

  assign ra_idx = ir_q[RA_LSB +: REG_AW];
  assign rb_idx = ir_q[RB_LSB +: REG_AW];
  assign rc_idx = ir_q[RC_LSB +: REG_AW];

  // State, IR and latched immediate-select registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      imm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  // Next state; IR and seq_imm only update while idle.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    unique case (state_q)
      IDLE: begin
        if (ir_load) ir_d = ir_in;
        if (seq_start) begin
          state_d = READ_B;
          imm_d   = seq_imm;
        end
      end
      READ_B:  state_d = READ_C;
      READ_C:  state_d = WRITE_A;
      WRITE_A: if (res_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state index selection and strobes; manual inputs only matter when idle.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    in_stb   = 1'b0;
    out_stb  = 1'b0;
    ba_stb   = 1'b0;
    c_drv    = 1'b0;
    opa_drv  = 1'b0;
    opb_drv  = 1'b0;
    done_drv = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gra) begin
          sel_vld = 1'b1;
          sel_idx = ra_idx;
        end else if (grb) begin
          sel_vld = 1'b1;
          sel_idx = rb_idx;
        end else if (grc) begin
          sel_vld = 1'b1;
          sel_idx = rc_idx;
        end
        in_stb  = rin;
        out_stb = rout | baout;
        ba_stb  = baout;
      end
      READ_B: begin
        sel_vld = 1'b1;
        sel_idx = rb_idx;
        out_stb = 1'b1;
        opa_drv = 1'b1;
      end
      READ_C: begin
        sel_vld = 1'b1;
        sel_idx = rc_idx;
        out_stb = ~imm_q;
        c_drv   = imm_q;
        opb_drv = 1'b1;
      end
      WRITE_A: begin
        sel_vld = 1'b1;
        sel_idx = ra_idx;
        in_stb  = res_valid;
      end
      DONE:    done_drv = 1'b1;
      default: ;
    endcase
  end

  reg_decoder #(
    .AW (REG_AW)
  ) u_reg_decoder (
    .idx    (sel_idx),
    .en     (sel_vld & ~reset),
    .onehot (dec_oh)
  );

  assign idx_zero = (sel_idx == '0);

  // Outputs are held low while reset is asserted.
  assign reg_in   = in_stb ? dec_oh : '0;
  assign reg_out  = (out_stb & ~(ba_stb & idx_zero)) ? dec_oh : '0;
  assign zero_out = sel_vld & ba_stb & idx_zero & ~reset;
  assign c_out    = c_drv & ~reset;
  assign opa_load = opa_drv & ~reset;
  assign opb_load = opb_drv & ~reset;
  assign seq_done = done_drv & ~reset;
  assign seq_busy = (state_q != IDLE) & ~reset;
  assign c_sext   = reset ? '0 : DATA_W'(sign_extend(SEXT_MAX_W'(ir_q), C_W));

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Directed plus randomized bench for reg_select_sequencer (16- and 32-register builds).
module tb_reg_select_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_in;
  logic        ir_load, gra, grb, grc, rin, rout, baout;
  logic        seq_start, seq_imm, res_valid;

  logic [15:0] reg_in_a, reg_out_a;
  logic        zero_a, cout_a, opa_a, opb_a, busy_a, done_a;
  logic [31:0] csext_a;

  logic [31:0] reg_in_b, reg_out_b;
  logic        zero_b, cout_b, opa_b, opb_b, busy_b, done_b;
  logic [31:0] csext_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_select_sequencer u_a (
    .clk (clk), .reset (reset), .ir_in (ir_in), .ir_load (ir_load),
    .gra (gra), .grb (grb), .grc (grc), .rin (rin), .rout (rout), .baout (baout),
    .seq_start (seq_start), .seq_imm (seq_imm), .res_valid (res_valid),
    .reg_in (reg_in_a), .reg_out (reg_out_a), .zero_out (zero_a), .c_out (cout_a),
    .c_sext (csext_a), .opa_load (opa_a), .opb_load (opb_a),
    .seq_busy (busy_a), .seq_done (done_a)
  );

  reg_select_sequencer #(
    .REG_AW (5), .RA_LSB (25), .RB_LSB (20), .RC_LSB (15)
  ) u_b (
    .clk (clk), .reset (reset), .ir_in (ir_in), .ir_load (ir_load),
    .gra (gra), .grb (grb), .grc (grc), .rin (rin), .rout (rout), .baout (baout),
    .seq_start (seq_start), .seq_imm (seq_imm), .res_valid (res_valid),
    .reg_in (reg_in_b), .reg_out (reg_out_b), .zero_out (zero_b), .c_out (cout_b),
    .c_sext (csext_b), .opa_load (opa_b), .opb_load (opb_b),
    .seq_busy (busy_b), .seq_done (done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ir_load = 0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
    seq_start = 0; seq_imm = 0; res_valid = 0;
  endtask

  function automatic int fld(input logic [31:0] ir, input int lsb, input int w);
    return int'((ir >> lsb) & ((32'd1 << w) - 32'd1));
  endfunction

  // Reference: value of the 19-bit two's-complement field as a 32-bit word.
  function automatic logic [31:0] sext_model(input logic [31:0] ir);
    int c;
    c = int'(ir & 32'h0007_FFFF);
    if (c >= 32'h0004_0000) c = c - 32'h0008_0000;
    return 32'(c);
  endfunction

  task automatic load_ir(input logic [31:0] ir);
    adv();
    clear_inputs();
    ir_in = ir; ir_load = 1;
    adv();
    ir_load = 0;
  endtask

  // s = {gra, grb, grc, rin, rout, baout}; checks the 16-register build in idle.
  task automatic manual_check(input logic [31:0] ir, input logic [5:0] s, input string tag);
    bit sel; int idx;
    logic [63:0] e_in, e_out; bit e_z;
    load_ir(ir);
    {gra, grb, grc, rin, rout, baout} = s;
    sel = 1; idx = 0;
    if (s[5])      idx = fld(ir, 23, 4);
    else if (s[4]) idx = fld(ir, 19, 4);
    else if (s[3]) idx = fld(ir, 15, 4);
    else           sel = 0;
    e_in  = (sel && s[2]) ? (64'd1 << idx) : 64'd0;
    e_out = (sel && (s[1] || s[0]) && !(s[0] && idx == 0)) ? (64'd1 << idx) : 64'd0;
    e_z   = sel && s[0] && idx == 0;
    #2;
    chk({tag, ".reg_in"},  64'(reg_in_a),  e_in);
    chk({tag, ".reg_out"}, 64'(reg_out_a), e_out);
    chk({tag, ".zero"},    64'(zero_a),    64'(e_z));
    clear_inputs();
  endtask

  // Runs a full operand sequence; k = WRITE_A cycles with res_valid low.
  task automatic run_seq(input logic [31:0] ir, input bit imm, input int k,
                         input bit same, input bit noise, input string tag);
    int busy_n;
    int ra, rb, rc;
    logic [63:0] e_out, e_in;
    bit e_opa, e_opb, e_c, e_done;
    ra = fld(ir, 23, 4); rb = fld(ir, 19, 4); rc = fld(ir, 15, 4);
    adv();
    clear_inputs();
    if (!same) begin
      ir_in = ir; ir_load = 1;
      adv();
      ir_load = 0;
    end
    ir_in = ir; ir_load = same; seq_start = 1; seq_imm = imm;
    adv();
    clear_inputs();
    busy_n = 0;
    for (int c = 0; c < 4 + k; c++) begin
      if (noise) begin
        {gra, grb, grc, rin, rout, baout} = 6'($urandom);
        seq_start = 1'($urandom); seq_imm = 1'($urandom);
        ir_load = 1'($urandom); ir_in = $urandom;
      end
      if (c >= 2 && c < 2 + k) res_valid = 0;
      else if (c == 2 + k)     res_valid = 1;
      else                     res_valid = noise ? 1'($urandom) : 1'b0;
      e_out = 0; e_in = 0; e_opa = 0; e_opb = 0; e_c = 0; e_done = 0;
      if (c == 0) begin e_out = 64'd1 << rb; e_opa = 1; end
      if (c == 1) begin e_opb = 1; e_c = imm; e_out = imm ? 64'd0 : (64'd1 << rc); end
      if (c == 2 + k) e_in = 64'd1 << ra;
      if (c == 3 + k) e_done = 1;
      #2;
      chk({tag, ".reg_out"}, 64'(reg_out_a), e_out);
      chk({tag, ".reg_in"},  64'(reg_in_a),  e_in);
      chk({tag, ".opa"},     64'(opa_a),     64'(e_opa));
      chk({tag, ".opb"},     64'(opb_a),     64'(e_opb));
      chk({tag, ".c_out"},   64'(cout_a),    64'(e_c));
      chk({tag, ".done"},    64'(done_a),    64'(e_done));
      chk({tag, ".zero"},    64'(zero_a),    64'd0);
      if (busy_a) busy_n++;
      adv();
    end
    clear_inputs();
    #2;
    chk({tag, ".idle_busy"}, 64'(busy_a),  64'd0);
    chk({tag, ".idle_done"}, 64'(done_a),  64'd0);
    chk({tag, ".busy_len"},  64'(busy_n),  64'(4 + k));
    chk({tag, ".c_sext"},    64'(csext_a), 64'(sext_model(ir)));
  endtask

  initial begin
    logic [31:0] ir;

    // Reset with every input high.
    reset = 1; ir_in = '1; ir_load = 1; gra = 1; grb = 1; grc = 1; rin = 1; rout = 1;
    baout = 1; seq_start = 1; seq_imm = 1; res_valid = 1;
    adv();
    adv();
    #2;
    chk("rst.reg_in",  64'(reg_in_a),  64'd0);
    chk("rst.reg_out", 64'(reg_out_a), 64'd0);
    chk("rst.zero",    64'(zero_a),    64'd0);
    chk("rst.c_out",   64'(cout_a),    64'd0);
    chk("rst.c_sext",  64'(csext_a),   64'd0);
    chk("rst.opab",    64'({opa_a, opb_a}), 64'd0);
    chk("rst.busy",    64'({busy_a, done_a}), 64'd0);
    chk("rst.b_out",   64'({reg_in_b, reg_out_b}), 64'd0);
    reset = 0;
    clear_inputs();

    // Sign extension of C.
    load_ir(32'h0000_4000);
    #2 chk("sext.pos", 64'(csext_a), 64'(sext_model(32'h0000_4000)));
    chk("sext.pos_lit", 64'(csext_a), 64'h0000_0000_0000_4000);
    load_ir(32'h0004_0000);
    #2 chk("sext.neg", 64'(csext_a), 64'h0000_0000_FFFC_0000);

    // Manual mode, directed.
    ir = (32'd5 << 23) | (32'd9 << 19);
    manual_check(ir, 6'b110010, "man.gra_grb_rout");
    manual_check(ir, 6'b010100, "man.grb_rin");
    ir = (32'd5 << 23);
    manual_check(ir, 6'b010001, "man.ba_zero");
    manual_check(ir, 6'b010010, "man.rout_zero");
    load_ir(ir);
    grb = 1; baout = 1;
    #2 chk("man.ba_lit", 64'({zero_a, reg_out_a}), 64'h1_0000);
    clear_inputs();

    // 32-register build, index 31.
    load_ir(32'd31 << 25);
    gra = 1; rout = 1;
    #2 chk("b32.rout", 64'(reg_out_b), 64'h8000_0000);
    chk("b32.rin0", 64'(reg_in_b), 64'd0);
    rout = 0; rin = 1;
    #1 chk("b32.rin", 64'(reg_in_b), 64'h8000_0000);
    clear_inputs();

    // Randomized manual mode.
    for (int i = 0; i < 20; i++) manual_check($urandom, 6'($urandom), "man.rnd");

    // Directed sequences.
    ir = (32'd3 << 23) | (32'd4 << 19) | (32'd7 << 15);
    run_seq(ir, 1'b0, 2, 1'b0, 1'b0, "seq.reg");
    run_seq(ir | 32'h0004_1234, 1'b1, 1, 1'b0, 1'b1, "seq.imm_noise");
    run_seq(32'h0123_4567, 1'b0, 0, 1'b1, 1'b0, "seq.same_cycle");

    // Randomized sequences.
    for (int i = 0; i < 10; i++)
      run_seq($urandom, 1'($urandom), int'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), "seq.rnd");

    // Reset during WRITE_A with res_valid high.
    load_ir(ir);
    seq_start = 1;
    adv();
    seq_start = 0;
    adv();
    adv();
    #2 chk("rmid.busy_wa", 64'(busy_a), 64'd1);
    res_valid = 1; reset = 1;
    #1;
    chk("rmid.reg_in", 64'(reg_in_a), 64'd0);
    chk("rmid.done",   64'(done_a),   64'd0);
    adv();
    reset = 0; res_valid = 0;
    #2;
    chk("rmid.idle",    64'(busy_a),   64'd0);
    chk("rmid.done2",   64'(done_a),   64'd0);
    chk("rmid.reg_in2", 64'(reg_in_a), 64'd0);
    adv();
    #2 chk("rmid.stay", 64'({busy_a, done_a}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
